// File: rtl/step_sequencer_if.sv
// step_sequencer_if: control inputs and step/status outputs of the microcode step sequencer
//   master: drives clk_en, i_adv, i_len, i_halt, i_resume, i_single_step, i_step_btn
//   slave : drives o_step, o_step_onehot, o_fetch, o_last, o_halted, o_instr_done, o_instr_count
interface step_sequencer_if #(
    parameter int MAX_STEPS   = 8,
    parameter int COUNT_WIDTH = 16
);
    localparam int SW = $clog2(MAX_STEPS);
    localparam int LW = $clog2(MAX_STEPS + 1);
    logic                   clk_en;
    logic                   i_adv;
    logic [LW-1:0]          i_len;
    logic                   i_halt;
    logic                   i_resume;
    logic                   i_single_step;
    logic                   i_step_btn;
    logic [SW-1:0]          o_step;
    logic [MAX_STEPS-1:0]   o_step_onehot;
    logic                   o_fetch;
    logic                   o_last;
    logic                   o_halted;
    logic                   o_instr_done;
    logic [COUNT_WIDTH-1:0] o_instr_count;
    modport master (
        output clk_en, i_adv, i_len, i_halt, i_resume, i_single_step, i_step_btn,
        input  o_step, o_step_onehot, o_fetch, o_last, o_halted, o_instr_done, o_instr_count
    );
    modport slave (
        input  clk_en, i_adv, i_len, i_halt, i_resume, i_single_step, i_step_btn,
        output o_step, o_step_onehot, o_fetch, o_last, o_halted, o_instr_done, o_instr_count
    );
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: microcode step counter with fetch phase, early end, halt and single-step
//   clk, rst : clock and asynchronous active-high reset
//   bus      : step_sequencer_if.slave (control inputs, step index/decode, status, retired count)
module step_sequencer #(
    parameter int MAX_STEPS   = 8,
    parameter int FETCH_STEPS = 2,
    parameter int COUNT_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    step_sequencer_if.slave  bus
);
    localparam int SW = $clog2(MAX_STEPS);
    localparam int LW = $clog2(MAX_STEPS + 1);
    typedef enum logic {RUN, HALT} state_t;
    state_t                 state_q, state_d;
    logic [SW-1:0]          step_q, step_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   done_q, done_d;
    logic                   btn_prev_q, btn_prev_d;
    logic [LW-1:0]          eff_len;
    logic [LW-1:0]          step_ext;
    logic                   run;
    logic                   fetch;
    logic                   adv_early;
    logic                   wrap;
    logic                   btn_rise;
    logic                   adv_ok;
    assign eff_len = (bus.i_len == '0 || bus.i_len > LW'(MAX_STEPS)) ? LW'(MAX_STEPS) :
                     (bus.i_len <= LW'(FETCH_STEPS)) ? LW'(FETCH_STEPS + 1) : bus.i_len;
    assign step_ext  = LW'(step_q);
    assign run       = state_q == RUN;
    assign fetch     = step_ext < LW'(FETCH_STEPS);
    assign adv_early = bus.i_adv & ~fetch;
    // Wrap uses >= so a length shortened below the current step still ends the instruction.
    assign wrap      = (step_ext >= eff_len - LW'(1)) | adv_early;
    assign btn_rise  = bus.i_step_btn & ~btn_prev_q;
    assign adv_ok    = bus.clk_en & run & ~bus.i_halt & (~bus.i_single_step | btn_rise);
    always_comb begin
        state_d    = run ? ((bus.clk_en & bus.i_halt) ? HALT : RUN)
                         : ((bus.clk_en & bus.i_resume & ~bus.i_halt) ? RUN : HALT);
        step_d     = adv_ok ? (wrap ? '0 : step_q + SW'(1)) : step_q;
        count_d    = (adv_ok & wrap) ? count_q + COUNT_WIDTH'(1) : count_q;
        done_d     = adv_ok & wrap;
        btn_prev_d = bus.clk_en ? bus.i_step_btn : btn_prev_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            step_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            count_q    <= count_d;
            done_q     <= done_d;
            btn_prev_q <= btn_prev_d;
        end
    end
    assign bus.o_step        = step_q;
    assign bus.o_step_onehot = MAX_STEPS'(1) << step_q;
    assign bus.o_fetch       = fetch;
    assign bus.o_last        = (step_ext == eff_len - LW'(1)) | adv_early;
    assign bus.o_halted      = ~run;
    assign bus.o_instr_done  = done_q;
    assign bus.o_instr_count = count_q;
endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter MAX_STEPS, default 8, SHALL set the maximum microcode steps per instruction (legal range 2..256).
REQ-002 Parameter FETCH_STEPS, default 2, SHALL set the fixed fetch steps at the start of every instruction (legal range 1..MAX_STEPS-1).
REQ-003 Parameter COUNT_WIDTH, default 16, SHALL set the retired-instruction counter width.
REQ-004 Derived widths SHALL be: SW = clog2(MAX_STEPS); LW = clog2(MAX_STEPS+1).
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 clk_en  input  1  global advance enable; no state changes when 0, except reset.
REQ-008 i_adv  input  1  early end of the current instruction.
REQ-009 i_len  input  LW  step count of the current instruction, sampled every cycle.
REQ-010 i_halt  input  1  halt request.
REQ-011 i_resume  input  1  leave HALT.
REQ-012 i_single_step  input  1  single-step mode select.
REQ-013 i_step_btn  input  1  manual step level, rising edge advances one step.
REQ-014 o_step  output  SW  current step index.
REQ-015 o_step_onehot  output  MAX_STEPS  one-hot decode of o_step.
REQ-016 o_fetch  output  1  high while o_step < FETCH_STEPS.
REQ-017 o_last  output  1  high while o_step is the final step of the instruction.
REQ-018 o_halted  output  1  high in HALT state.
REQ-019 o_instr_done  output  1  one-cycle pulse, registered, in the cycle after an instruction wraps to step 0.
REQ-020 o_instr_count  output  COUNT_WIDTH  retired-instruction count, modulo 2^COUNT_WIDTH.

Function
REQ-021 Effective length L SHALL be MAX_STEPS if i_len==0 or i_len>MAX_STEPS, FETCH_STEPS+1 if i_len<=FETCH_STEPS, otherwise i_len.
REQ-022 o_last SHALL be combinational: (o_step == L-1) or (i_adv and not o_fetch).
REQ-023 States SHALL be RUN and HALT; a single-step gate SHALL qualify advance in RUN.
REQ-024 Advance qualifier adv_ok = clk_en & RUN & ~i_halt & (~i_single_step | btn_rise); btn_rise = i_step_btn & ~btn_prev; btn_prev SHALL be registered on every clk_en cycle.
REQ-025 On adv_ok, step SHALL become 0 if o_last, else step+1; o_step SHALL never exceed MAX_STEPS-1.
REQ-026 i_adv SHALL be ignored while o_fetch is high.
REQ-027 On adv_ok with o_last, o_instr_count SHALL increment by 1, wrapping to 0, and o_instr_done SHALL assert for exactly the next cycle.
REQ-028 RUN->HALT SHALL occur on clk_en & i_halt; step is not advanced that cycle.
REQ-029 HALT->RUN SHALL occur on clk_en & i_resume & ~i_halt; i_resume and i_halt together keep HALT.
REQ-030 In HALT, o_step, o_instr_count and the one-hot output SHALL hold; o_instr_done SHALL be 0.
REQ-031 Changing i_len mid-instruction SHALL take effect immediately; if o_step >= new L-1, the next advance SHALL wrap to 0.
REQ-032 Holding i_step_btn high SHALL advance exactly one step.

Reset
REQ-033 rst SHALL force immediately: state RUN, o_step=0, o_step_onehot=1, o_instr_count=0, o_instr_done=0, btn_prev=0. This SHALL also apply mid-instruction and in HALT.
REQ-034 After deassertion of rst, the first adv_ok SHALL move o_step to 1.

Verification
REQ-035 Defaults, i_len=5, clk_en=1, 12 cycles -> o_step 0,1,2,3,4,0,1,2,3,4,0,1; o_instr_done high 1 cycle after each wrap; o_instr_count=2.
REQ-036 i_len=0 and i_len=9 -> 8-step cycles; i_len=1 -> 3-step cycles (0,1,2).
REQ-037 i_adv high at step 1 -> no effect; i_adv at step 3 -> o_last=1, next o_step=0, count+1.
REQ-038 i_halt at step 2 -> o_halted=1, o_step stays 2 for 10 cycles; i_resume+i_halt -> still halted; i_resume alone -> RUN, next step 3.
REQ-039 i_single_step=1, i_step_btn held 5 cycles -> one advance; three separate pulses -> o_step +3; clk_en=0 during a pulse -> no advance.
REQ-040 COUNT_WIDTH=2, 5 retirements -> count 1; rst asserted at step 3 while halted -> outputs take reset values at once.
